hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline sequencer for the 3-stage RISC-V core (IF/ID, X, MW). It takes decoded register fields and control bits from the `control_unit` outputs of each stage. It resolves data hazards with forwarding selects and load-use stalls, and squashes wrong-path fetches after reset and taken branches/jumps. It also maintains the cycle and retired-instruction counters exposed through CSR/MMIO.

## Interface
Parameters:
- `CNT_W`, 32, width of `cycle_cnt` and `instr_cnt`.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  the ID instruction actually reads that source.
- `x_rd`  in  5  destination register of the X-stage instruction.
- `x_reg_wen`, `x_is_load`, `x_valid`  in  1 each  RegWEn, load flag (WBSel = mem), and valid bit of the X-stage instruction.
- `x_redirect`  in  1  taken branch or jump resolved in X (PCSel ≠ PC+4).
- `w_rd`  in  5  destination register of the MW-stage instruction.
- `w_reg_wen`, `w_valid`  in  1 each  RegWEn and valid bit of the MW-stage instruction.
- `cnt_clr`  in  1  MMIO write to the counter-reset address.
- `fwd_a_sel`, `fwd_b_sel`  out  2 each  operand source: 0 = regfile, 1 = X ALU result, 2 = MW writeback data.
- `pc_stall`  out  1  hold PC and the IF/ID register.
- `id_bubble`  out  1  load a NOP (valid = 0) into X next edge.
- `id_kill`  out  1  clear the valid bit of the instruction currently in ID.
- `cycle_cnt`, `instr_cnt`  out  `CNT_W` each  counters.
- `state`  out  2  FSM state, for debug.

## Operation
FSM states:
- RST_WAIT = 0: entered on reset. `id_kill` = 1, because the synchronous IMEM/BIOS output is not yet valid. Moves to RUN after one cycle.
- RUN = 1: normal issue.
  - `x_redirect` = 1 → `id_kill` = 1 this cycle, and the FSM moves to REDIRECT.
- REDIRECT = 2: `id_kill` = 1. The fetch issued in the redirect cycle is also wrong-path. Moves to RUN after one cycle.
- State 3 is unused and must decode to RST_WAIT on the next edge.

Forwarding (combinational, evaluated per source, shown for A; B is identical):
- `fwd_a_sel` = 1 if `id_uses_rs1` & `x_valid` & `x_reg_wen` & !`x_is_load` & `x_rd` == `id_rs1` & `x_rd` ≠ 0.
- Otherwise `fwd_a_sel` = 2 if `id_uses_rs1` & `w_valid` & `w_reg_wen` & `w_rd` == `id_rs1` & `w_rd` ≠ 0.
- Otherwise `fwd_a_sel` = 0.
- X has priority over MW. x0 is never forwarded.

Load-use stall (combinational, RUN only):
- Fires when `x_valid` & `x_is_load` & `x_reg_wen` & `x_rd` ≠ 0 & `x_rd` matches a used ID source.
- Response: `pc_stall` = 1 and `id_bubble` = 1 for exactly one cycle.
- On the next cycle the load is in MW, and the dependent instruction gets `fwd_sel` = 2.

Priorities:
- `x_redirect` overrides the load-use stall: `pc_stall` = 0 and `id_bubble` = 0, `id_kill` = 1.
- In RST_WAIT and REDIRECT, `pc_stall` and `id_bubble` are 0. A killed instruction is never stalled.

Counters:
- `cycle_cnt` increments on every edge where `rst_n` = 1.
- `instr_cnt` increments on every edge where `w_valid` = 1.
- Both wrap modulo 2^`CNT_W`.
- `cnt_clr` = 1 loads 0 into both counters, overriding any increment on the same edge.

## Timing
- Reset values:
  - `state` = RST_WAIT; both counters 0.
  - `pc_stall` = 0, `id_bubble` = 0, `id_kill` = 1, `fwd_a_sel` = `fwd_b_sel` = 0.
- `rst_n` low in the middle of a stall or redirect returns the FSM to RST_WAIT on that edge; nothing else is retained.
- Forwarding and stall outputs are purely combinational from the current-cycle inputs plus `state`, with zero latency.
- `id_kill` is combinational from `state` and `x_redirect`. It is asserted for exactly 2 consecutive cycles per redirect and for exactly 1 cycle after reset release.
- A redirect arriving in REDIRECT's successor RUN cycle starts a fresh 2-cycle kill window.
- Counter outputs are registered and visible the cycle after the event.

## Test plan
- Reset release: hold `rst_n` = 0 for 3 cycles, then release → cycle 0 after release has `state` = 0 and `id_kill` = 1; cycle 1 has `state` = 1 and `id_kill` = 0; `cycle_cnt` = 1 at cycle 1.
- Forwarding priority: `x_rd` = `w_rd` = `id_rs1` = 5, both writing, X not a load → `fwd_a_sel` = 1. Then set `x_rd` = 0 → `fwd_a_sel` = 2. Then `id_rs1` = 0 with `w_rd` = 0 → `fwd_a_sel` = 0.
- Load-use: `x_is_load` = 1, `x_rd` = 7, `id_rs2` = 7, `id_uses_rs2` = 1 → `pc_stall` = `id_bubble` = 1 for one cycle. Next cycle with `w_rd` = 7 → `fwd_b_sel` = 2 and no stall. Same scenario with `id_uses_rs2` = 0 → no stall.
- Redirect: `x_redirect` pulses for 1 cycle in RUN → `id_kill` high for 2 cycles and `state` sequence 1, 2, 1. With a simultaneous load-use match, `pc_stall` = 0.
- Counters: 10 cycles with `w_valid` high on 6 of them → `instr_cnt` = 6. `cnt_clr` asserted together with `w_valid` → both counters 0 the next cycle. Preload `cycle_cnt` = 0xFFFFFFFF → next value 0.
- Mid-operation reset: assert `rst_n` = 0 during REDIRECT → `state` = 0, counters 0, `id_kill` = 1 on the next edge.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline stage registers / control_unit outputs and hazard_ctrl.
// The stage valid bits qualify their stage's fields. There is no valid/ready handshake; pc_stall is the only backpressure.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       x_rd;
  logic             x_reg_wen;
  logic             x_is_load;
  logic             x_valid;
  logic             x_redirect;
  logic [4:0]       w_rd;
  logic             w_reg_wen;
  logic             w_valid;
  logic             cnt_clr;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             pc_stall;
  logic             id_bubble;
  logic             id_kill;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;
  logic [1:0]       state;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output x_rd, x_reg_wen, x_is_load, x_valid, x_redirect,
    output w_rd, w_reg_wen, w_valid, cnt_clr,
    input  fwd_a_sel, fwd_b_sel, pc_stall, id_bubble, id_kill,
    input  cycle_cnt, instr_cnt, state
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  x_rd, x_reg_wen, x_is_load, x_valid, x_redirect,
    input  w_rd, w_reg_wen, w_valid, cnt_clr,
    output fwd_a_sel, fwd_b_sel, pc_stall, id_bubble, id_kill,
    output cycle_cnt, instr_cnt, state
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard sequencer for the 3-stage core: operand forwarding, load-use stall,
// wrong-path fetch squash after reset/redirect, and cycle/retire counters.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input logic         clk,
  input logic         rst_n,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RST_WAIT = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2,
    UNUSED   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instr_q;

  logic x_fwd_ok;
  logic w_fwd_ok;
  logic x_load_ok;
  logic a_x_hit;
  logic a_w_hit;
  logic b_x_hit;
  logic b_w_hit;
  logic load_use;
  logic in_run;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RST_WAIT;
    end else begin
      case (state_q)
        RST_WAIT: state_q <= RUN;
        RUN:      state_q <= bus.x_redirect ? REDIRECT : RUN;
        REDIRECT: state_q <= RUN;
        default:  state_q <= RST_WAIT;
      endcase
    end
  end

  // Clear wins over the increment on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.cnt_clr) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_q + CNT_ONE;
      instr_q <= instr_q + {{(CNT_W-1){1'b0}}, bus.w_valid};
    end
  end

  // A load's data is not available from X, so it can only forward once it reaches MW.
  assign x_fwd_ok  = bus.x_valid && bus.x_reg_wen && !bus.x_is_load && (bus.x_rd != 5'd0);
  assign w_fwd_ok  = bus.w_valid && bus.w_reg_wen && (bus.w_rd != 5'd0);
  assign x_load_ok = bus.x_valid && bus.x_reg_wen && bus.x_is_load && (bus.x_rd != 5'd0);

  assign a_x_hit = bus.id_uses_rs1 && x_fwd_ok && (bus.x_rd == bus.id_rs1);
  assign a_w_hit = bus.id_uses_rs1 && w_fwd_ok && (bus.w_rd == bus.id_rs1);
  assign b_x_hit = bus.id_uses_rs2 && x_fwd_ok && (bus.x_rd == bus.id_rs2);
  assign b_w_hit = bus.id_uses_rs2 && w_fwd_ok && (bus.w_rd == bus.id_rs2);

  assign bus.fwd_a_sel = a_x_hit ? 2'd1 : (a_w_hit ? 2'd2 : 2'd0);
  assign bus.fwd_b_sel = b_x_hit ? 2'd1 : (b_w_hit ? 2'd2 : 2'd0);

  assign load_use = x_load_ok &&
                    ((bus.id_uses_rs1 && (bus.x_rd == bus.id_rs1)) ||
                     (bus.id_uses_rs2 && (bus.x_rd == bus.id_rs2)));

  // A killed ID instruction is never stalled, so the stall only exists in RUN without a redirect.
  assign in_run        = (state_q == RUN);
  assign bus.pc_stall  = in_run && !bus.x_redirect && load_use;
  assign bus.id_bubble = in_run && !bus.x_redirect && load_use;
  assign bus.id_kill   = !in_run || bus.x_redirect;

  assign bus.state     = state_q;
  assign bus.cycle_cnt = cycle_q;
  assign bus.instr_cnt = instr_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized cycles checked
// against a cycle-level model of the kill windows, forwarding rules and counters.
module tb_hazard_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  hazard_ctrl_if #(.CNT_W(32)) hif ();
  hazard_ctrl_if #(.CNT_W(4))  wif ();

  hazard_ctrl #(.CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(hif.slave));
  hazard_ctrl #(.CNT_W(4))  dut_w (.clk(clk), .rst_n(rst_n), .bus(wif.slave));

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit          m_post_reset;  // first cycle after reset, fetch not valid yet
  bit          m_redir_tail;  // second cycle of a redirect kill window
  logic [31:0] exp_cycle;
  logic [31:0] exp_instr;

  function automatic logic [1:0] exp_state();
    if (m_post_reset) return 2'd0;
    if (m_redir_tail) return 2'd2;
    return 2'd1;
  endfunction

  function automatic logic exp_kill();
    return m_post_reset || m_redir_tail || hif.x_redirect;
  endfunction

  function automatic logic exp_stall();
    logic hit;
    hit = hif.x_valid && hif.x_is_load && hif.x_reg_wen && (hif.x_rd != 0) &&
          ((hif.id_uses_rs1 && hif.x_rd == hif.id_rs1) || (hif.id_uses_rs2 && hif.x_rd == hif.id_rs2));
    return !m_post_reset && !m_redir_tail && !hif.x_redirect && hit;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic uses, input logic [4:0] rs);
    if (!uses || rs == 5'd0) return 2'd0;
    if (hif.x_valid && hif.x_reg_wen && !hif.x_is_load && hif.x_rd == rs) return 2'd1;
    if (hif.w_valid && hif.w_reg_wen && hif.w_rd == rs) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_update();
    bit running;
    if (!rst_n) begin
      m_post_reset = 1'b1;
      m_redir_tail = 1'b0;
      exp_cycle    = '0;
      exp_instr    = '0;
    end else begin
      running      = !m_post_reset && !m_redir_tail;
      m_redir_tail = running && hif.x_redirect;
      m_post_reset = 1'b0;
      if (hif.cnt_clr) begin
        exp_cycle = '0;
        exp_instr = '0;
      end else begin
        exp_cycle = exp_cycle + 32'd1;
        exp_instr = exp_instr + {31'd0, hif.w_valid};
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hif.id_rs1 = '0; hif.id_rs2 = '0; hif.id_uses_rs1 = 1'b0; hif.id_uses_rs2 = 1'b0;
    hif.x_rd = '0; hif.x_reg_wen = 1'b0; hif.x_is_load = 1'b0; hif.x_valid = 1'b0; hif.x_redirect = 1'b0;
    hif.w_rd = '0; hif.w_reg_wen = 1'b0; hif.w_valid = 1'b0; hif.cnt_clr = 1'b0;
  endtask

  task automatic set_load_use_rs2();
    hif.x_valid = 1'b1; hif.x_reg_wen = 1'b1; hif.x_is_load = 1'b1; hif.x_rd = 5'd7;
    hif.id_rs2 = 5'd7; hif.id_uses_rs2 = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (3) tick();
    n_checks++; if (hif.state !== 2'd0) begin n_fail++; $display("FAIL rst_state got %0d exp 0", hif.state); end
    n_checks++; if (hif.id_kill !== 1'b1) begin n_fail++; $display("FAIL rst_kill got %0b exp 1", hif.id_kill); end
    n_checks++; if (hif.pc_stall !== 1'b0 || hif.id_bubble !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %0b/%0b exp 0/0", hif.pc_stall, hif.id_bubble); end
    n_checks++; if (hif.fwd_a_sel !== 2'd0 || hif.fwd_b_sel !== 2'd0) begin n_fail++; $display("FAIL rst_fwd got %0d/%0d exp 0/0", hif.fwd_a_sel, hif.fwd_b_sel); end
    n_checks++; if (hif.cycle_cnt !== 32'd0 || hif.instr_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", hif.cycle_cnt, hif.instr_cnt); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (hif.state !== 2'd0 || hif.id_kill !== 1'b1) begin n_fail++; $display("FAIL rel_c0 got state %0d kill %0b exp 0/1", hif.state, hif.id_kill); end
    n_checks++; if (hif.cycle_cnt !== 32'd0) begin n_fail++; $display("FAIL rel_c0_cycle got %0d exp 0", hif.cycle_cnt); end
    tick();
    n_checks++; if (hif.state !== 2'd1 || hif.id_kill !== 1'b0) begin n_fail++; $display("FAIL rel_c1 got state %0d kill %0b exp 1/0", hif.state, hif.id_kill); end
    n_checks++; if (hif.cycle_cnt !== 32'd1) begin n_fail++; $display("FAIL rel_c1_cycle got %0d exp 1", hif.cycle_cnt); end
  endtask

  task automatic test_forward();
    clear_inputs();
    hif.x_valid = 1'b1; hif.x_reg_wen = 1'b1; hif.x_rd = 5'd5;
    hif.w_valid = 1'b1; hif.w_reg_wen = 1'b1; hif.w_rd = 5'd5;
    hif.id_rs1 = 5'd5; hif.id_uses_rs1 = 1'b1;
    #1;
    n_checks++; if (hif.fwd_a_sel !== 2'd1) begin n_fail++; $display("FAIL fwd_x_prio got %0d exp 1", hif.fwd_a_sel); end
    hif.x_rd = 5'd0;
    #1;
    n_checks++; if (hif.fwd_a_sel !== 2'd2) begin n_fail++; $display("FAIL fwd_w got %0d exp 2", hif.fwd_a_sel); end
    hif.id_rs1 = 5'd0; hif.w_rd = 5'd0;
    #1;
    n_checks++; if (hif.fwd_a_sel !== 2'd0) begin n_fail++; $display("FAIL fwd_x0 got %0d exp 0", hif.fwd_a_sel); end
    hif.id_rs2 = 5'd9; hif.id_uses_rs2 = 1'b1; hif.w_rd = 5'd9; hif.x_rd = 5'd9;
    #1;
    n_checks++; if (hif.fwd_b_sel !== 2'd1) begin n_fail++; $display("FAIL fwd_b_x got %0d exp 1", hif.fwd_b_sel); end
    hif.x_valid = 1'b0;
    #1;
    n_checks++; if (hif.fwd_b_sel !== 2'd2) begin n_fail++; $display("FAIL fwd_b_w got %0d exp 2", hif.fwd_b_sel); end
    hif.id_uses_rs2 = 1'b0;
    #1;
    n_checks++; if (hif.fwd_b_sel !== 2'd0) begin n_fail++; $display("FAIL fwd_b_unused got %0d exp 0", hif.fwd_b_sel); end
    clear_inputs();
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    set_load_use_rs2();
    #1;
    n_checks++; if (hif.pc_stall !== 1'b1 || hif.id_bubble !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %0b/%0b exp 1/1", hif.pc_stall, hif.id_bubble); end
    n_checks++; if (hif.fwd_b_sel !== 2'd0) begin n_fail++; $display("FAIL lu_no_xfwd got %0d exp 0", hif.fwd_b_sel); end
    tick();
    clear_inputs();
    hif.id_rs2 = 5'd7; hif.id_uses_rs2 = 1'b1;
    hif.w_valid = 1'b1; hif.w_reg_wen = 1'b1; hif.w_rd = 5'd7;
    #1;
    n_checks++; if (hif.fwd_b_sel !== 2'd2) begin n_fail++; $display("FAIL lu_next_fwd got %0d exp 2", hif.fwd_b_sel); end
    n_checks++; if (hif.pc_stall !== 1'b0) begin n_fail++; $display("FAIL lu_next_stall got %0b exp 0", hif.pc_stall); end
    tick();
    clear_inputs();
    set_load_use_rs2();
    hif.id_uses_rs2 = 1'b0;
    #1;
    n_checks++; if (hif.pc_stall !== 1'b0 || hif.id_bubble !== 1'b0) begin n_fail++; $display("FAIL lu_unused got %0b/%0b exp 0/0", hif.pc_stall, hif.id_bubble); end
    clear_inputs();
    tick();
  endtask

  task automatic test_redirect();
    clear_inputs();
    for (int rep = 0; rep < 2; rep++) begin
      hif.x_redirect = 1'b1;
      #1;
      n_checks++; if (hif.state !== 2'd1 || hif.id_kill !== 1'b1) begin n_fail++; $display("FAIL redir_c0 rep %0d got state %0d kill %0b exp 1/1", rep, hif.state, hif.id_kill); end
      tick();
      hif.x_redirect = 1'b0;
      #1;
      n_checks++; if (hif.state !== 2'd2 || hif.id_kill !== 1'b1) begin n_fail++; $display("FAIL redir_c1 rep %0d got state %0d kill %0b exp 2/1", rep, hif.state, hif.id_kill); end
      tick();
      n_checks++; if (hif.state !== 2'd1 || hif.id_kill !== 1'b0) begin n_fail++; $display("FAIL redir_c2 rep %0d got state %0d kill %0b exp 1/0", rep, hif.state, hif.id_kill); end
    end
    set_load_use_rs2();
    hif.x_redirect = 1'b1;
    #1;
    n_checks++; if (hif.pc_stall !== 1'b0 || hif.id_bubble !== 1'b0 || hif.id_kill !== 1'b1) begin n_fail++; $display("FAIL redir_over_lu got stall %0b bubble %0b kill %0b exp 0/0/1", hif.pc_stall, hif.id_bubble, hif.id_kill); end
    tick();
    clear_inputs();
    set_load_use_rs2();
    #1;
    n_checks++; if (hif.pc_stall !== 1'b0 || hif.id_kill !== 1'b1) begin n_fail++; $display("FAIL redir_tail_lu got stall %0b kill %0b exp 0/1", hif.pc_stall, hif.id_kill); end
    clear_inputs();
    tick();
  endtask

  task automatic test_counters();
    logic [9:0] pat;
    pat = 10'b1011011010;
    clear_inputs();
    hif.cnt_clr = 1'b1;
    tick();
    hif.cnt_clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      hif.w_valid = pat[i];
      tick();
    end
    hif.w_valid = 1'b0;
    #1;
    n_checks++; if (hif.instr_cnt !== 32'd6) begin n_fail++; $display("FAIL cnt_instr got %0d exp 6", hif.instr_cnt); end
    n_checks++; if (hif.cycle_cnt !== 32'd10) begin n_fail++; $display("FAIL cnt_cycle got %0d exp 10", hif.cycle_cnt); end
    hif.cnt_clr = 1'b1; hif.w_valid = 1'b1;
    tick();
    clear_inputs();
    #1;
    n_checks++; if (hif.cycle_cnt !== 32'd0 || hif.instr_cnt !== 32'd0) begin n_fail++; $display("FAIL cnt_clr got %0d/%0d exp 0/0", hif.cycle_cnt, hif.instr_cnt); end
  endtask

  task automatic test_wrap();
    wif.cnt_clr = 1'b1;
    tick();
    wif.cnt_clr = 1'b0;
    repeat (15) tick();
    n_checks++; if (wif.cycle_cnt !== 4'hF || wif.instr_cnt !== 4'hF) begin n_fail++; $display("FAIL wrap_max got %0h/%0h exp f/f", wif.cycle_cnt, wif.instr_cnt); end
    tick();
    n_checks++; if (wif.cycle_cnt !== 4'h0 || wif.instr_cnt !== 4'h0) begin n_fail++; $display("FAIL wrap_zero got %0h/%0h exp 0/0", wif.cycle_cnt, wif.instr_cnt); end
  endtask

  task automatic test_mid_reset();
    clear_inputs();
    hif.w_valid = 1'b1;
    hif.x_redirect = 1'b1;
    tick();
    hif.x_redirect = 1'b0;
    #1;
    n_checks++; if (hif.state !== 2'd2) begin n_fail++; $display("FAIL mid_pre got state %0d exp 2", hif.state); end
    rst_n = 1'b0;
    tick();
    n_checks++; if (hif.state !== 2'd0 || hif.id_kill !== 1'b1) begin n_fail++; $display("FAIL mid_rst got state %0d kill %0b exp 0/1", hif.state, hif.id_kill); end
    n_checks++; if (hif.cycle_cnt !== 32'd0 || hif.instr_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_rst_cnt got %0d/%0d exp 0/0", hif.cycle_cnt, hif.instr_cnt); end
    rst_n = 1'b1;
    clear_inputs();
    tick();
    n_checks++; if (hif.state !== 2'd1) begin n_fail++; $display("FAIL mid_rel got state %0d exp 1", hif.state); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n           = ($urandom_range(0, 49) != 0);
      hif.id_rs1      = 5'($urandom_range(0, 3));
      hif.id_rs2      = 5'($urandom_range(0, 3));
      hif.id_uses_rs1 = 1'($urandom_range(0, 1));
      hif.id_uses_rs2 = 1'($urandom_range(0, 1));
      hif.x_rd        = 5'($urandom_range(0, 3));
      hif.x_reg_wen   = ($urandom_range(0, 3) != 0);
      hif.x_is_load   = ($urandom_range(0, 2) == 0);
      hif.x_valid     = ($urandom_range(0, 3) != 0);
      hif.x_redirect  = ($urandom_range(0, 5) == 0);
      hif.w_rd        = 5'($urandom_range(0, 3));
      hif.w_reg_wen   = ($urandom_range(0, 3) != 0);
      hif.w_valid     = 1'($urandom_range(0, 1));
      hif.cnt_clr     = ($urandom_range(0, 39) == 0);
      #1;
      n_checks++; if (hif.state !== exp_state()) begin n_fail++; $display("FAIL rnd_state cyc %0d got %0d exp %0d", i, hif.state, exp_state()); end
      n_checks++; if (hif.id_kill !== exp_kill()) begin n_fail++; $display("FAIL rnd_kill cyc %0d got %0b exp %0b", i, hif.id_kill, exp_kill()); end
      n_checks++; if (hif.pc_stall !== exp_stall()) begin n_fail++; $display("FAIL rnd_stall cyc %0d got %0b exp %0b", i, hif.pc_stall, exp_stall()); end
      n_checks++; if (hif.id_bubble !== exp_stall()) begin n_fail++; $display("FAIL rnd_bubble cyc %0d got %0b exp %0b", i, hif.id_bubble, exp_stall()); end
      n_checks++; if (hif.fwd_a_sel !== exp_fwd(hif.id_uses_rs1, hif.id_rs1)) begin n_fail++; $display("FAIL rnd_fwd_a cyc %0d got %0d exp %0d", i, hif.fwd_a_sel, exp_fwd(hif.id_uses_rs1, hif.id_rs1)); end
      n_checks++; if (hif.fwd_b_sel !== exp_fwd(hif.id_uses_rs2, hif.id_rs2)) begin n_fail++; $display("FAIL rnd_fwd_b cyc %0d got %0d exp %0d", i, hif.fwd_b_sel, exp_fwd(hif.id_uses_rs2, hif.id_rs2)); end
      n_checks++; if (hif.cycle_cnt !== exp_cycle) begin n_fail++; $display("FAIL rnd_cycle cyc %0d got %0d exp %0d", i, hif.cycle_cnt, exp_cycle); end
      n_checks++; if (hif.instr_cnt !== exp_instr) begin n_fail++; $display("FAIL rnd_instr cyc %0d got %0d exp %0d", i, hif.instr_cnt, exp_instr); end
      tick();
    end
    rst_n = 1'b1;
    clear_inputs();
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    wif.id_rs1 = '0; wif.id_rs2 = '0; wif.id_uses_rs1 = 1'b0; wif.id_uses_rs2 = 1'b0;
    wif.x_rd = '0; wif.x_reg_wen = 1'b0; wif.x_is_load = 1'b0; wif.x_valid = 1'b0; wif.x_redirect = 1'b0;
    wif.w_rd = '0; wif.w_reg_wen = 1'b0; wif.w_valid = 1'b1; wif.cnt_clr = 1'b0;
    clear_inputs();
    test_reset();
    test_forward();
    test_load_use();
    test_redirect();
    test_counters();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
